mbist_fail_log: RTL
===================

Name: mbist_fail_log

Overview:
- Consumer side of the MBIST compare path: receives per-cycle compare results (address, expected word, actual RAM word) from the BIST datapath.
- Records failing compares in a first-word-fall-through FIFO.
- Exposes the FIFO to a host/diagnosis reader through a valid/ready pop interface.
- Maintains a saturating fail counter, an overflow flag and a pass/fail verdict per test run.

Parameters:
- WCOUNT, 256: RAM word count; address width AW = $clog2(WCOUNT).
- WLENGTH, 4: RAM word width.
- DEPTH, 8: log FIFO entries, power of two, >= 2.
- CNTW, 12: fail_count width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- test_start  in  1  pulse; clear the log and begin logging.
- test_done  in  1  pulse; end of march sequence.
- cmp_valid  in  1  compare result valid this cycle (read phase only).
- cmp_fail  in  1  compare mismatch (qualified by cmp_valid).
- cmp_addr  in  AW  address of the compared word.
- cmp_exp  in  WLENGTH  expected data.
- cmp_act  in  WLENGTH  data read from RAM.
- rd_ready  in  1  reader accepts head entry.
- rd_valid  out  1  FIFO non-empty.
- rd_addr  out  AW  head entry address.
- rd_exp  out  WLENGTH  head entry expected data.
- rd_act  out  WLENGTH  head entry actual data.
- fail_count  out  CNTW  failing compares this run, saturating.
- overflow  out  1  at least one fail was dropped because the FIFO was full.
- busy  out  1  state == LOG.
- done  out  1  state == DONE.
- pass  out  1  done && fail_count == 0.

Behaviour:
- Reset: rst synchronous, active-high; clock clk. Reset clears state to IDLE, FIFO empty, and drives all outputs to 0: rd_valid, rd_addr, rd_exp, rd_act, fail_count, overflow, busy, done, pass.
- FSM states: IDLE, LOG, DONE.
  - IDLE -> LOG on test_start.
  - LOG -> DONE on test_done.
  - DONE -> LOG on test_start.
  - test_start in LOG restarts the run: clear, stay in LOG.
  - test_start has priority over test_done in the same cycle.
- Clear on test_start, taking effect at the next edge:
  - FIFO pointers emptied; fail_count, overflow, done and pass all set to 0.
  - cmp_* and rd_ready are ignored in the test_start cycle.
- Capture:
  - Only in LOG, and only when cmp_valid && cmp_fail.
  - Entry {cmp_addr, cmp_exp, cmp_act} is pushed at the edge.
  - cmp_* are ignored in IDLE and DONE.
- Counter: fail_count increments on every capture event, whether or not the entry is stored. It holds at all-ones (saturate) and never wraps.
- Full:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle; occupancy is then unchanged.
  - Otherwise the entry is dropped and overflow is set to 1, sticky until the next clear.
- Simultaneous events:
  - test_done together with a capture: the fail is logged and counted, then the FSM enters DONE.
  - Simultaneous push and pop on a non-empty FIFO: both occur.
- Read interface (FWFT):
  - rd_valid = (occupancy != 0). rd_addr, rd_exp and rd_act show the head entry.
  - Pop when rd_valid && rd_ready; the next entry appears the following cycle.
  - While rd_valid && !rd_ready, the outputs are held stable.
  - rd_ready while empty has no effect.
  - Pops are allowed in LOG and DONE; none in IDLE, where the FIFO is always empty.
  - When rd_valid = 0, rd_* hold their last value; they are don't-care.
- Latency: a fail captured at edge N is visible as rd_valid = 1 after edge N if the FIFO was empty (one cycle).
- Pointers: log2(DEPTH)+1 bits each; wrap naturally modulo 2*DEPTH. Full when the MSBs differ and the lower bits are equal.
- done and pass:
  - Both are registered; they assert the cycle after the LOG->DONE transition.
  - pass = 1 only with zero fails; an overflowed run is always pass = 0.
- Reset mid-run: immediate return to IDLE with all state cleared; in-flight entries are lost.

Test Plan:
- Clean run: test_start; 256 cmp_valid=1, cmp_fail=0; test_done -> one cycle later done=1, pass=1, fail_count=0, rd_valid=0.
- Single fail: in LOG, cmp_fail at addr 0x3A, exp 0xF, act 0xB -> next cycle rd_valid=1, rd_addr=0x3A, rd_exp=0xF, rd_act=0xB. Hold rd_ready=0 for 5 cycles: outputs stable. Pulse rd_ready -> rd_valid=0. After test_done: pass=0, fail_count=1.
- Overflow: 10 consecutive fails at addrs 0..9 with rd_ready=0 -> fail_count=10, overflow=1. Readout yields addrs 0..7 in order, then rd_valid=0.
- Full with simultaneous pop: fill 8 entries, then hold rd_ready=1 while 4 more fails arrive -> no overflow. Total 12 entries read, in order.
- Priority and ignore: test_done with a fail at addr 0xFF in the same cycle -> entry logged, done=1. A later cmp_fail in DONE -> fail_count unchanged. test_start and test_done together in DONE -> LOG, all state cleared.
- Saturation and reset: with CNTW=4, 20 fails -> fail_count=15. Assert rst mid-run -> IDLE, all outputs 0, rd_valid=0.

Source files
------------

// File: rtl/mbist_fail_log.sv
// MBIST fail logger: captures failing compares into a first-word-fall-through FIFO,
// counts fails (saturating), flags dropped entries and produces a per-run verdict.
module mbist_fail_log #(
    parameter int WCOUNT  = 256,
    parameter int WLENGTH = 4,
    parameter int DEPTH   = 8,
    parameter int CNTW    = 12,
    localparam int AW     = $clog2(WCOUNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               test_start,
    input  logic               test_done,
    input  logic               cmp_valid,
    input  logic               cmp_fail,
    input  logic [AW-1:0]      cmp_addr,
    input  logic [WLENGTH-1:0] cmp_exp,
    input  logic [WLENGTH-1:0] cmp_act,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [AW-1:0]      rd_addr,
    output logic [WLENGTH-1:0] rd_exp,
    output logic [WLENGTH-1:0] rd_act,
    output logic [CNTW-1:0]    fail_count,
    output logic               overflow,
    output logic               busy,
    output logic               done,
    output logic               pass
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 2 * WLENGTH;
    localparam logic [PW:0]     PTR_ONE = 1;
    localparam logic [CNTW-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOG,
        DONE
    } state_t;

    state_t         state;
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  head;
    logic [EW-1:0]  entry;
    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;
    logic [PW:0]    rd_ptr_inc;
    logic [PW:0]    occupancy;
    logic           empty;
    logic           full;
    logic           capture;
    logic           pop;
    logic           push_ok;
    logic [CNTW-1:0] cnt_next;
    logic           ovf_next;

    assign entry      = {cmp_addr, cmp_exp, cmp_act};
    assign rd_ptr_inc = rd_ptr + PTR_ONE;
    assign occupancy  = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign rd_valid = !empty;
    assign rd_addr  = head[EW-1 -: AW];
    assign rd_exp   = head[2*WLENGTH-1 -: WLENGTH];
    assign rd_act   = head[WLENGTH-1:0];

    // A test_start cycle only clears: compares and reads in that cycle are ignored.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        capture  = 1'b0;
        pop      = 1'b0;
        push_ok  = 1'b0;
        cnt_next = fail_count;
        ovf_next = overflow;
        if (!test_start) begin
            capture = (state == LOG) && cmp_valid && cmp_fail;
            pop     = (state != IDLE) && !empty && rd_ready;
        end
        push_ok = capture && (!full || pop);
        if (capture && (fail_count != '1)) begin
            cnt_next = fail_count + CNT_ONE;
        end
        if (capture && !push_ok) begin
            ovf_next = 1'b1;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the pointers alone,
    // and the head register that drives rd_* is reset separately.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PW-1:0]] <= entry;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head       <= '0;
            fail_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (test_start) begin
            state      <= LOG;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fail_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end

            // Head register keeps the FWFT view; the array slot behind it is refilled from mem.
            if (empty) begin
                if (push_ok) begin
                    head <= entry;
                end
            end else if (pop) begin
                if (occupancy > PTR_ONE) begin
                    head <= mem[rd_ptr_inc[PW-1:0]];
                end else if (push_ok) begin
                    head <= entry;
                end
            end

            fail_count <= cnt_next;
            overflow   <= ovf_next;

            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                end
                LOG: begin
                    if (test_done) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (cnt_next == '0) && !ovf_next;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
